// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core load/store path and an
// external burst master. The core wins by default; a starvation counter forces an external beat.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [DW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ext_start,
  input  logic          ext_we,
  input  logic [DW-1:0] ext_addr,
  input  logic [3:0]    ext_len,
  input  logic          ext_valid,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ready,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic          ext_busy,
  output logic          ext_done,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t        state_q, state_d;
  logic [DW-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic          ext_win;
  logic          mem_we_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beat_cnt_q   <= '0;
      len_q        <= '0;
      wait_cnt_q   <= '0;
      dir_q        <= 1'b0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      wait_cnt_q   <= wait_cnt_d;
      dir_q        <= dir_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    wait_cnt_d   = wait_cnt_q;
    dir_d        = dir_q;
    ext_rdata_d  = ext_rdata_q;
    ext_rvalid_d = 1'b0;
    ext_win      = 1'b0;
    mem_addr     = core_addr;
    mem_wdata    = core_wdata;
    mem_we_raw   = core_req & core_we;
    ext_ready    = 1'b0;
    core_stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ext_start) begin
          cur_addr_d = ext_addr;
          dir_d      = ext_we;
          len_d      = ext_len;
          beat_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = BURST;
        end
      end

      BURST: begin
        // The external side only displaces the core once it has waited MAX_WAIT cycles.
        ext_win = ext_valid & (~core_req | (wait_cnt_q == MAX_WAIT_C));
        if (ext_win) begin
          mem_addr   = cur_addr_q;
          mem_wdata  = ext_wdata;
          mem_we_raw = dir_q;
          ext_ready  = 1'b1;
          core_stall = core_req;
          wait_cnt_d = '0;
          cur_addr_d = cur_addr_q + DW'(4);
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (!dir_q) begin
            ext_rvalid_d = 1'b1;
            ext_rdata_d  = mem_rdata;
          end
          if (beat_cnt_q == len_q) begin
            state_d = DONE;
          end
        end else if (ext_valid && core_req && (wait_cnt_q != MAX_WAIT_C)) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gating with the reset keeps a held core store from reaching memory during reset.
  assign mem_we     = rst & mem_we_raw;
  assign core_rdata = mem_rdata;
  assign ext_rdata  = ext_rdata_q;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_busy   = (state_q == BURST);
  assign ext_done   = (state_q == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model
// attached to the mem_* port; expected values are hand-computed constants.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ext_start;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [3:0]  ext_len;
  logic        ext_valid;
  logic [31:0] ext_wdata;
  logic        ext_ready;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic        ext_busy;
  logic        ext_done;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  bit   [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  int errors;
  int checks;

  dmem_arbiter #(.MAX_WAIT(4), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .ext_start  (ext_start),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_len    (ext_len),
    .ext_valid  (ext_valid),
    .ext_wdata  (ext_wdata),
    .ext_ready  (ext_ready),
    .ext_rdata  (ext_rdata),
    .ext_rvalid (ext_rvalid),
    .ext_busy   (ext_busy),
    .ext_done   (ext_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read memory; the preload port lets the bench seed words during reset.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    next_cycle();
    pre_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] core_val;
    logic        prev_stall;
    logic        exp_stall;
    errors = 0;
    checks = 0;
    pre_we = 0; pre_idx = '0; pre_val = '0;
    rst = 0;
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'h11;
    ext_start = 0; ext_we = 0; ext_addr = '0; ext_len = '0; ext_valid = 0; ext_wdata = '0;

    // Reset with a core store pending
    preload(8'd16, 32'hCAFE0000);
    preload(8'd128, 32'hDEADBEEF);
    preload(8'd129, 32'h12345678);
    @(negedge clk);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_busy", ext_busy, 0);
    checkOutput("rst_done", ext_done, 0);
    checkOutput("rst_ready", ext_ready, 0);
    checkOutput("rst_stall", core_stall, 0);
    checkOutput("rst_rvalid", ext_rvalid, 0);
    checkOutput("rst_rdata", ext_rdata, 0);

    next_cycle();
    rst = 1;
    @(negedge clk);
    checkOutput("idle_mem_we", mem_we, 1);
    checkOutput("idle_stall", core_stall, 0);
    checkOutput("idle_addr", mem_addr, 32'h40);
    checkOutput("idle_rdata_pre", core_rdata, 32'hCAFE0000);
    next_cycle();
    core_req = 0;
    @(negedge clk);
    checkOutput("idle_rdata_post", core_rdata, 32'h11);
    checkOutput("idle_noreq_we", mem_we, 0);

    // Write burst of 4 beats at 0x100, with a stray ext_start mid-burst
    next_cycle();
    ext_start = 1; ext_we = 1; ext_addr = 32'h100; ext_len = 4'd3;
    @(negedge clk);
    checkOutput("wr_start_busy", ext_busy, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ext_start = (i == 1);
      ext_addr  = (i == 1) ? 32'h300 : 32'h100;
      ext_we    = (i == 1) ? 1'b0 : 1'b1;
      ext_valid = 1;
      ext_wdata = 32'hA0 + 32'(i);
      @(negedge clk);
      checkOutput("wr_busy", ext_busy, 1);
      checkOutput("wr_ready", ext_ready, 1);
      checkOutput("wr_mem_we", mem_we, 1);
      checkOutput("wr_addr", mem_addr, 32'h100 + 32'(4 * i));
      checkOutput("wr_wdata", mem_wdata, 32'hA0 + 32'(i));
    end
    next_cycle();
    ext_valid = 0; ext_start = 0;
    @(negedge clk);
    checkOutput("wr_done", ext_done, 1);
    checkOutput("wr_done_busy", ext_busy, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("wr_done_clear", ext_done, 0);
    checkOutput("wr_idle_busy", ext_busy, 0);
    checkOutput("wr_mem0", mem[64], 32'hA0);
    checkOutput("wr_mem3", mem[67], 32'hA3);

    // Read burst of 2 beats at 0x200
    next_cycle();
    ext_start = 1; ext_we = 0; ext_addr = 32'h200; ext_len = 4'd1;
    next_cycle();
    ext_start = 0; ext_valid = 1;
    @(negedge clk);
    checkOutput("rd_ready0", ext_ready, 1);
    checkOutput("rd_mem_we", mem_we, 0);
    checkOutput("rd_addr0", mem_addr, 32'h200);
    checkOutput("rd_rvalid_early", ext_rvalid, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("rd_rvalid0", ext_rvalid, 1);
    checkOutput("rd_rdata0", ext_rdata, 32'hDEADBEEF);
    checkOutput("rd_addr1", mem_addr, 32'h204);
    next_cycle();
    ext_valid = 0;
    @(negedge clk);
    checkOutput("rd_rvalid1", ext_rvalid, 1);
    checkOutput("rd_rdata1", ext_rdata, 32'h12345678);
    checkOutput("rd_done", ext_done, 1);
    next_cycle();
    @(negedge clk);
    checkOutput("rd_rvalid_off", ext_rvalid, 0);
    checkOutput("rd_done_off", ext_done, 0);

    // Starvation: core stores every cycle, external beats forced on cycles 5 and 10
    next_cycle();
    ext_start = 1; ext_we = 1; ext_addr = 32'h180; ext_len = 4'd1;
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'h500;
    prev_stall = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      ext_start = 0;
      ext_valid = 1;
      ext_wdata = (c <= 5) ? 32'hE1 : 32'hE2;
      if (!prev_stall) core_wdata = 32'h500 + 32'(c);
      exp_stall = (c == 5) || (c == 10);
      @(negedge clk);
      checkOutput("stv_stall", core_stall, 32'(exp_stall));
      checkOutput("stv_ready", ext_ready, 32'(exp_stall));
      checkOutput("stv_addr", mem_addr, exp_stall ? ((c == 5) ? 32'h180 : 32'h184) : 32'h40);
      checkOutput("stv_wdata", mem_wdata, exp_stall ? ext_wdata : core_wdata);
      if (c == 6) checkOutput("stv_held", mem_wdata, 32'h505);
      if (c == 7) checkOutput("stv_store_kept", mem[16], 32'h505);
      prev_stall = exp_stall;
    end
    core_val = core_wdata;
    next_cycle();
    ext_valid = 0;
    @(negedge clk);
    checkOutput("stv_done", ext_done, 1);
    checkOutput("stv_done_stall", core_stall, 0);
    checkOutput("stv_done_wdata", mem_wdata, core_val);
    next_cycle();
    core_req = 0;
    @(negedge clk);
    checkOutput("stv_core_mem", mem[16], 32'h50A);
    checkOutput("stv_beat1_mem", mem[96], 32'hE1);
    checkOutput("stv_beat2_mem", mem[97], 32'hE2);

    // Address wrap at the top of the address space
    next_cycle();
    ext_start = 1; ext_we = 1; ext_addr = 32'hFFFFFFFC; ext_len = 4'd1;
    next_cycle();
    ext_start = 0; ext_valid = 1; ext_wdata = 32'hF0;
    @(negedge clk);
    checkOutput("wrap_addr0", mem_addr, 32'hFFFFFFFC);
    next_cycle();
    ext_wdata = 32'hF1;
    @(negedge clk);
    checkOutput("wrap_addr1", mem_addr, 32'h00000000);
    checkOutput("wrap_ready1", ext_ready, 1);
    next_cycle();
    ext_valid = 0;
    @(negedge clk);
    checkOutput("wrap_done", ext_done, 1);

    // Reset in the middle of a 4-beat write
    next_cycle();
    ext_start = 1; ext_we = 1; ext_addr = 32'h140; ext_len = 4'd3;
    next_cycle();
    ext_start = 0; ext_valid = 1; ext_wdata = 32'hB0;
    @(negedge clk);
    checkOutput("mid_addr0", mem_addr, 32'h140);
    next_cycle();
    ext_wdata = 32'hB1;
    @(negedge clk);
    checkOutput("mid_addr1", mem_addr, 32'h144);
    next_cycle();
    rst = 0;
    #1;
    checkOutput("mid_rst_busy", ext_busy, 0);
    checkOutput("mid_rst_we", mem_we, 0);
    checkOutput("mid_rst_ready", ext_ready, 0);
    next_cycle();
    rst = 1;
    @(negedge clk);
    checkOutput("mid_post_busy", ext_busy, 0);
    checkOutput("mid_post_done", ext_done, 0);
    checkOutput("mid_post_we", mem_we, 0);
    checkOutput("mid_post_ready", ext_ready, 0);
    next_cycle();
    ext_valid = 0;
    @(negedge clk);
    checkOutput("mid_no_done", ext_done, 0);
    checkOutput("mid_beat1_mem", mem[81], 32'hB1);
    checkOutput("mid_beat2_mem", mem[82], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-ported data memory between the single-cycle core's load/store path and an external burst master (loader/DMA/debug).
- The core has priority.
- A starvation counter forces an external beat after MAX_WAIT denied cycles. On that beat the block stalls the core (PC hold, register write suppressed).
- Sits between the core's ALU-result/RD2 nets and the data memory's A/WD/WE/RD ports.

Parameters:
MAX_WAIT, 4, consecutive cycles an external beat may be denied before a forced grant (1..15)
DW, 32, data and address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
core_req  in  1  core needs memory this cycle (load or store)
core_we  in  1  core store
core_addr  in  DW  core byte address
core_wdata  in  DW  core store data
core_rdata  out  DW  memory read data to core (combinational pass-through)
core_stall  out  1  core access not serviced this cycle; hold PC, block RegWrite
ext_start  in  1  start burst (sampled only in IDLE)
ext_we  in  1  burst direction, 1 = write (latched at start)
ext_addr  in  DW  burst base byte address (latched at start)
ext_len  in  4  beats minus one (1..16 beats, latched at start)
ext_valid  in  1  master has write data / can accept read data
ext_wdata  in  DW  write beat data
ext_ready  out  1  beat accepted this cycle (combinational)
ext_rdata  out  DW  read beat data, registered
ext_rvalid  out  1  ext_rdata valid, one cycle after the read beat
ext_busy  out  1  state is BURST
ext_done  out  1  one-cycle pulse after the final beat
mem_we  out  1  to data memory WE
mem_addr  out  DW  to data memory A
mem_wdata  out  DW  to data memory WD
mem_rdata  in  DW  from data memory RD (asynchronous read)

Behaviour:
- States: IDLE, BURST, DONE.
- Registers: base address, beat counter (4 bits), direction, wait_cnt (4 bits).
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all registers clear.
  - ext_rdata=0, ext_rvalid=0, ext_busy=0, ext_done=0, ext_ready=0, core_stall=0.
  - mem_we forced 0 while rst=0.
- IDLE:
  - Core owns memory: mem_* = core_*, mem_we = core_req & core_we, core_stall=0.
  - ext_start=1 latches ext_addr/ext_we/ext_len, clears the beat counter and wait_cnt, and moves to BURST next cycle.
- BURST, per-cycle grant:
  - ext_win = ext_valid & (~core_req | wait_cnt==MAX_WAIT).
  - If ext_win:
    - mem_addr = cur_addr, mem_wdata = ext_wdata, mem_we = dir.
    - ext_ready=1; core_stall = core_req.
    - wait_cnt is cleared; the address advances by 4 (modulo 2^DW); the beat counter increments.
  - Otherwise:
    - Core drives memory as in IDLE; ext_ready=0.
    - wait_cnt increments iff ext_valid & core_req (saturating at MAX_WAIT).
  - ext_valid=0 with core_req=0: memory idle, mem_we=0, wait_cnt unchanged.
  - Read beat: ext_rdata <= mem_rdata, ext_rvalid=1 on the next cycle. ext_rvalid is 0 on all other cycles and never asserts for writes.
  - Beat with counter == len moves to DONE.
- DONE: ext_done=1 for exactly one cycle, core owns memory, then IDLE.
- ext_start outside IDLE is ignored (no queuing).
- core_rdata = mem_rdata at all times. It is meaningful to the core only when core_stall=0.
- A stalled core holds core_req/core_addr/core_wdata stable; the access completes on the next cycle that is not stalled.
  - Consecutive stalls are impossible: wait_cnt is 0 after a forced beat, so the core's next request wins.
- Worst-case external throughput with core_req held high: 1 beat per MAX_WAIT+1 cycles.
- Reset mid-burst: abandon immediately. No ext_done, no partial-beat write after reset; ext_rvalid drops.

Test Plan:
- Reset with core_req=1, core_we=1 -> mem_we=0, all outputs 0. Release -> mem_we=1, core_stall=0, core_rdata tracks mem_rdata.
- Write burst base 0x100, ext_len=3, ext_valid=1, core_req=0 -> 4 consecutive beats at 0x100/104/108/10C with ext_wdata on mem_wdata, mem_we=1, ext_ready=1 each cycle; ext_done pulses in the cycle after the beat at 0x10C; ext_busy=1 for 4 cycles.
- Read burst base 0x200, ext_len=1, memory holds 0xDEADBEEF at 0x200 and 0x12345678 at 0x204 -> ext_rvalid=1 with those values on the two cycles after each beat.
- Write burst ext_len=1 with core_req held 1, MAX_WAIT=4 -> ext denied 4 cycles, beat 1 forced on cycle 5 with core_stall=1. Cycle 6: core wins. Beat 2 forced on cycle 10 (cycles counted from the first BURST cycle). Core store is never lost.
- Burst base 0xFFFFFFFC, ext_len=1 -> beats at 0xFFFFFFFC then 0x00000000.
- Assert rst=0 after beat 2 of a 4-beat write -> state IDLE, ext_busy=0, no ext_done, no further mem_we from the ext side. ext_start pulsed during BURST is ignored; the second burst starts only after ext_done.
